// File: rtl/mdu_pkg.sv
// mdu_pkg: shared state enum, default width and counter-width helper for the multiply sequencer
package mdu_pkg;

    localparam int MDU_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    function automatic int clog2(input int n);
        int r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if: EX-stage multiply request/response bundle
//   master (EX side): drives start, is_signed, op_a, op_b, flush; sees stall, busy, done, hi, lo
//   slave (sequencer): the mirror image
interface mdu_sequencer_if #(parameter int WIDTH = 32) ();

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, is_signed, op_a, op_b, flush,
                    input  stall, busy, done, hi, lo);
    modport slave  (input  start, is_signed, op_a, op_b, flush,
                    output stall, busy, done, hi, lo);

endinterface

// File: rtl/mdu_shift_add.sv
// mdu_shift_add: one radix-2 shift-add step of the unsigned multiplier
//   acc, mcand, mplr : current upper product half, multiplicand, multiplier/lower half
//   acc_nx, mplr_nx  : the same after one conditional add and a right shift
module mdu_shift_add #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplr,
    output logic [WIDTH-1:0] acc_nx,
    output logic [WIDTH-1:0] mplr_nx
);

    // one extra bit keeps the carry so it shifts into acc instead of being lost
    logic [WIDTH:0] sum;

    assign sum     = mplr[0] ? {1'b0, acc} + {1'b0, mcand} : {1'b0, acc};
    assign acc_nx  = sum[WIDTH:1];
    assign mplr_nx = {sum[0], mplr[WIDTH-1:1]};

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative MULT/MULTU unit writing HI/LO and stalling the pipeline
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of mdu_sequencer_if (request in, stall/busy/done/hi/lo out)
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH_DEFAULT
) (
    input logic            clk,
    input logic            rst_n,
    mdu_sequencer_if.slave bus
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state, state_nx;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   acc, mcand, mplr, acc_nx, mplr_nx;
    logic [WIDTH-1:0]   abs_a, abs_b, hi, lo;
    logic [2*WIDTH-1:0] prod;
    logic               neg, accept, busy;

    // signed operands are multiplied as magnitudes; the sign is restored in FIX
    assign abs_a = (bus.is_signed && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
    assign abs_b = (bus.is_signed && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
    assign prod  = neg ? ~{acc, mplr} + 1'b1 : {acc, mplr};
    assign bus.hi = hi;
    assign bus.lo = lo;

    mdu_shift_add #(.WIDTH(WIDTH)) u_step (
        .acc    (acc),
        .mcand  (mcand),
        .mplr   (mplr),
        .acc_nx (acc_nx),
        .mplr_nx(mplr_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // flush overrides every transition, including a start accepted in the same cycle
    always_comb begin
        accept    = bus.start && !bus.flush && (state == IDLE || state == DONE);
        busy      = state == CALC || state == FIX;
        state_nx  = bus.flush                    ? IDLE :
                    accept                       ? CALC :
                    (state == CALC && count == LAST) ? FIX :
                    state == FIX                 ? DONE :
                    state == DONE                ? IDLE : state;
        bus.busy  = busy;
        bus.done  = state == DONE;
        bus.stall = busy || (bus.start && (state == IDLE || state == DONE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            neg   <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (accept) begin
                count <= '0;
                acc   <= '0;
                mcand <= abs_a;
                mplr  <= abs_b;
                neg   <= bus.is_signed && (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            end else if (state == CALC) begin
                count <= count + 1'b1;
                acc   <= acc_nx;
                mplr  <= mplr_nx;
            end
            if (state == FIX && !bus.flush) {hi, lo} <= prod;
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: scoreboard bench for mdu_sequencer against a 64-bit arithmetic reference
module tb_mdu_sequencer;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    logic [63:0] last_exp = '0;
    logic [63:0] ref_hl = '0;

    mdu_sequencer_if #(.WIDTH(32)) bus ();

    mdu_sequencer #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        return s ? 64'(sa * sb) : 64'(ua * ub);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && bus.done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 hi=%h lo=%h required no done (cycle %0d)", bus.hi, bus.lo, cyc);
            end else begin
                e = q.pop_front();
                check("hi", bus.hi, e.hi);
                check("lo", bus.lo, e.lo);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit s, input bit push);
        logic [63:0] p;
        bus.start = 1'b1;
        bus.op_a = a;
        bus.op_b = b;
        bus.is_signed = s;
        if (push) begin
            p = model(a, b, s);
            q.push_back('{p[63:32], p[31:0], cyc + 34});
            last_exp = p;
        end
        #1;
        check("stall_c0", bus.stall, 1);
        check("busy_c0", bus.busy, 0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op_a = $urandom;
        bus.op_b = $urandom;
    endtask

    task automatic wait_done(output int stalls);
        bit got = 0;
        stalls = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1;
                break;
            end
            if (bus.stall) stalls++;
        end
        check("done_seen", got, 1);
        if (got) begin
            check("stall_at_done", bus.stall, 0);
            ref_hl = last_exp;
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input bit s);
        int n;
        @(posedge clk);
        #1;
        issue(a, b, s, 1);
        wait_done(n);
        check("stall_cycles", n, 33);
    endtask

    initial begin
        int n;
        logic [31:0] corners[5];
        logic [31:0] ra, rb;
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        bus.start = 0;
        bus.flush = 0;
        bus.is_signed = 0;
        bus.op_a = 0;
        bus.op_b = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_stall", bus.stall, 0);
        @(posedge clk);
        #1;
        rst_n = 1;

        run(32'd7, 32'd6, 0);
        run(32'hFFFF_FFFD, 32'd5, 1);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run(32'h8000_0000, 32'h8000_0000, 1);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);

        // back-to-back: new pair presented in the DONE cycle
        run(32'd11, 32'd13, 0);
        issue(32'd2, 32'd3, 0, 1);
        wait_done(n);

        // start during CALC must be ignored
        @(posedge clk);
        #1;
        issue(32'd5, 32'd5, 0, 1);
        repeat (9) @(posedge clk);
        #1;
        bus.start = 1;
        bus.op_a = 32'd123;
        bus.op_b = 32'd456;
        @(posedge clk);
        #1;
        bus.start = 0;
        wait_done(n);

        // flush in CALC cycle 10
        @(posedge clk);
        #1;
        issue(32'd9, 32'd9, 0, 0);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1;
        @(posedge clk);
        #1;
        bus.flush = 0;
        check("flush_calc_busy", bus.busy, 0);
        repeat (40) @(negedge clk);
        check("flush_calc_hi", bus.hi, ref_hl[63:32]);
        check("flush_calc_lo", bus.lo, ref_hl[31:0]);

        // flush coincident with FIX
        @(posedge clk);
        #1;
        issue(32'd100, 32'd100, 0, 0);
        repeat (32) @(posedge clk);
        #1;
        check("fix_busy", bus.busy, 1);
        bus.flush = 1;
        @(posedge clk);
        #1;
        bus.flush = 0;
        check("flush_fix_done", bus.done, 0);
        check("flush_fix_busy", bus.busy, 0);
        check("flush_fix_hi", bus.hi, ref_hl[63:32]);
        check("flush_fix_lo", bus.lo, ref_hl[31:0]);

        // start with flush in the same cycle is rejected
        @(posedge clk);
        #1;
        bus.start = 1;
        bus.flush = 1;
        bus.op_a = 32'd4;
        bus.op_b = 32'd4;
        @(posedge clk);
        #1;
        bus.start = 0;
        bus.flush = 0;
        check("flush_start_busy", bus.busy, 0);
        repeat (40) @(negedge clk);

        // reset in CALC cycle 5
        @(posedge clk);
        #1;
        issue(32'd77, 32'd88, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        check("arst_hi", bus.hi, 0);
        check("arst_lo", bus.lo, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_stall", bus.stall, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        ref_hl = '0;
        run(32'd1, 32'd1, 0);

        for (int i = 0; i < 20; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
            run(ra, rb, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("pending_results", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
